// File: rtl/spi_pkg.sv
// Shared types for the SPI transfer controller: FSM state encoding and SPI mode constants.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      RUN,
      DRAIN,
      DONE
   } state_t;

   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_fifo.sv
// Synchronous WIDTH x DEPTH FIFO with occupancy count; head reads as zero when empty.
module spi_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign do_push  = push && (count != CNT_W'(DEPTH));
   assign do_pop   = pop && (count != '0);
   assign pop_data = (count == '0) ? '0 : mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Command sequencer between a host (TX/RX FIFOs + command port) and an spi_master.
// state | meaning
// IDLE  | ready for a command
// WAIT  | command latched; waiting for TX data and RX space
// RUN   | issuing tx/rx starts to the master
// DRAIN | all bytes issued; waiting for cs_n to rise
// DONE  | one-cycle completion, xfer_done high
module spi_xfer_ctrl
   import spi_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_mode,
   input  logic [LEN_W-1:0] cmd_tx_len,
   input  logic [LEN_W-1:0] cmd_rx_len,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [WIDTH-1:0] tx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             xfer_done,
   output logic             cmd_err,
   output logic [1:0]       m_mode,
   output logic             m_tx_start,
   output logic             m_rx_start,
   output logic [WIDTH-1:0] m_data_in,
   input  logic             m_load,
   input  logic             m_read,
   input  logic             m_tx_done,
   input  logic             m_rx_done,
   input  logic [WIDTH-1:0] m_data_out,
   input  logic             m_cs_n
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int CMP_W = (LEN_W > CNT_W) ? LEN_W : CNT_W;

   state_t           state, state_nxt;
   logic [LEN_W-1:0] tx_len_q, rx_len_q, tx_left, rx_left, rx_cnt;
   logic [1:0]       mode_q;
   logic             load_q, read_q, rx_done_q;
   logic             load_rise, read_rise, rx_done_rise;
   logic [CNT_W-1:0] tx_count, rx_count;
   logic             accept, len_bad, cmd_err_q;
   logic             tx_fits, rx_fits, run_end;

   assign accept  = (state == IDLE) && cmd_valid;
   assign len_bad = (CMP_W'(cmd_tx_len) > CMP_W'(DEPTH)) || (CMP_W'(cmd_rx_len) > CMP_W'(DEPTH));

   assign load_rise    = (state != IDLE) && m_load && !load_q;
   assign read_rise    = (state != IDLE) && m_read && !read_q;
   assign rx_done_rise = (state != IDLE) && m_rx_done && !rx_done_q;

   assign tx_fits = CMP_W'(tx_count) >= CMP_W'(tx_len_q);
   assign rx_fits = (CMP_W'(DEPTH) - CMP_W'(rx_count)) >= CMP_W'(rx_len_q);
   assign run_end = (tx_left == '0) && (rx_left == '0) && (rx_cnt == rx_len_q);

   assign cmd_ready = (state == IDLE);
   assign xfer_done = (state == DONE);
   assign cmd_err   = cmd_err_q;
   assign m_mode    = mode_q;
   assign tx_ready  = (tx_count != CNT_W'(DEPTH));
   assign rx_valid  = (rx_count != '0);

   spi_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (tx_valid),
      .push_data (tx_data),
      .pop       (load_rise),
      .pop_data  (m_data_in),
      .count     (tx_count)
   );

   spi_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rx_done_rise),
      .push_data (m_data_out),
      .pop       (rx_ready),
      .pop_data  (rx_data),
      .count     (rx_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cmd_err_q <= 1'b0;
         mode_q    <= MODE0;
         tx_len_q  <= '0;
         rx_len_q  <= '0;
         tx_left   <= '0;
         rx_left   <= '0;
         rx_cnt    <= '0;
         load_q    <= 1'b0;
         read_q    <= 1'b0;
         rx_done_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         cmd_err_q <= accept && len_bad;
         if (state == IDLE) begin
            load_q    <= 1'b0;
            read_q    <= 1'b0;
            rx_done_q <= 1'b0;
         end else begin
            load_q    <= m_load;
            read_q    <= m_read;
            rx_done_q <= m_rx_done;
         end
         if (accept && !len_bad) begin
            mode_q   <= cmd_mode;
            tx_len_q <= cmd_tx_len;
            rx_len_q <= cmd_rx_len;
            tx_left  <= cmd_tx_len;
            rx_left  <= cmd_rx_len;
            rx_cnt   <= '0;
         end else begin
            if (load_rise && tx_left != '0) tx_left <= tx_left - 1'b1;
            if (read_rise && rx_left != '0) rx_left <= rx_left - 1'b1;
            if (rx_done_rise)               rx_cnt  <= rx_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      m_tx_start = 1'b0;
      m_rx_start = 1'b0;
      case (state)
         IDLE:    if (cmd_valid && !len_bad) state_nxt = WAIT;
         WAIT: begin
            if (tx_fits && rx_fits)
               state_nxt = (tx_len_q == '0 && rx_len_q == '0) ? DONE : RUN;
         end
         RUN: begin
            m_tx_start = (tx_left != '0);
            m_rx_start = (tx_left == '0) && (rx_left != '0);
            if (run_end) state_nxt = DRAIN;
         end
         DRAIN:   if (m_cs_n) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: behavioural byte-level spi_master with a MISO slave queue,
// a table of full commands, and directed sequences for WAIT holds, zero length and reset.
module tb_spi_xfer_ctrl;
   import spi_pkg::*;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int LEN_W = 4;

   logic             clk, rst_n;
   logic             cmd_valid, cmd_ready;
   logic [1:0]       cmd_mode;
   logic [LEN_W-1:0] cmd_tx_len, cmd_rx_len;
   logic             tx_valid, tx_ready;
   logic [WIDTH-1:0] tx_data;
   logic             rx_valid, rx_ready;
   logic [WIDTH-1:0] rx_data;
   logic             xfer_done, cmd_err;
   logic [1:0]       m_mode;
   logic             m_tx_start, m_rx_start;
   logic [WIDTH-1:0] m_data_in;
   logic             m_load, m_read, m_tx_done, m_rx_done;
   logic [WIDTH-1:0] m_data_out;
   logic             m_cs_n;

   spi_xfer_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
      .cmd_tx_len(cmd_tx_len), .cmd_rx_len(cmd_rx_len),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .xfer_done(xfer_done), .cmd_err(cmd_err),
      .m_mode(m_mode), .m_tx_start(m_tx_start), .m_rx_start(m_rx_start),
      .m_data_in(m_data_in), .m_load(m_load), .m_read(m_read),
      .m_tx_done(m_tx_done), .m_rx_done(m_rx_done),
      .m_data_out(m_data_out), .m_cs_n(m_cs_n)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   int         done_cnt = 0, err_cnt = 0, start_cnt = 0, cs_fall = 0;
   logic       cs_prev = 1'b1;
   logic [1:0] run_mode = 2'b00;
   logic [7:0] slave_q[$];
   logic [7:0] mosi_q[$];

   typedef struct packed {
      logic [1:0]      mode;
      logic [3:0]      tx_len;
      logic [3:0]      rx_len;
      logic [3:0][7:0] tx;
      logic [3:0][7:0] rx;
      logic            err;
   } vec_t;

   vec_t vecs [7];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Byte-level master: one load/read cycle, 8-cycle shift, one done pulse; cs_n rises when idle.
   initial begin : master_model
      int         mst_cnt;
      logic       mst_rx;
      logic [7:0] mosi_byte;
      mst_cnt = 0; mst_rx = 1'b0; mosi_byte = '0;
      m_load = 1'b0; m_read = 1'b0; m_tx_done = 1'b0; m_rx_done = 1'b0;
      m_data_out = '0; m_cs_n = 1'b1;
      forever begin
         @(posedge clk); #1;
         m_load = 1'b0; m_read = 1'b0; m_tx_done = 1'b0; m_rx_done = 1'b0;
         if (!rst_n) begin
            m_cs_n = 1'b1;
            mst_cnt = 0;
         end else if (mst_cnt != 0) begin
            mst_cnt--;
            if (mst_cnt == 0) begin
               if (mst_rx) begin
                  m_data_out = (slave_q.size() != 0) ? slave_q.pop_front() : 8'h00;
                  m_rx_done = 1'b1;
               end else begin
                  mosi_q.push_back(mosi_byte);
                  m_tx_done = 1'b1;
               end
            end
         end else if (m_tx_start) begin
            m_cs_n = 1'b0; m_load = 1'b1; mosi_byte = m_data_in; mst_rx = 1'b0; mst_cnt = 8;
         end else if (m_rx_start) begin
            m_cs_n = 1'b0; m_read = 1'b1; mst_rx = 1'b1; mst_cnt = 8;
         end else begin
            m_cs_n = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (xfer_done) done_cnt++;
      if (cmd_err) err_cnt++;
      if (m_tx_start || m_rx_start) begin
         start_cnt++;
         run_mode = m_mode;
      end
      if (cs_prev && !m_cs_n) cs_fall++;
      cs_prev = m_cs_n;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic tx_write(input logic [7:0] d);
      tx_valid = 1'b1; tx_data = d;
      step();
      tx_valid = 1'b0;
   endtask

   task automatic rx_pop_check(input string name, input logic [7:0] exp);
      check({name, "_valid"}, int'(rx_valid), 1);
      check({name, "_data"}, int'(rx_data), int'(exp));
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
   endtask

   task automatic send_cmd(input string name, input logic [1:0] mode,
                           input logic [3:0] tl, input logic [3:0] rl);
      check({name, "_cmd_ready"}, int'(cmd_ready), 1);
      cmd_mode = mode; cmd_tx_len = tl; cmd_rx_len = rl; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, input int d0);
      int cyc = 0;
      while (done_cnt == d0 && cyc < 2000) begin
         step();
         cyc++;
      end
      check({name, "_timeout"}, int'(cyc < 2000), 1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int    d0, e0, s0, f0;
      string nm;
      nm = $sformatf("v%0d", idx);
      mosi_q.delete();
      if (!v.err) begin
         for (int i = 0; i < int'(v.tx_len); i++) tx_write(v.tx[i]);
         for (int i = 0; i < int'(v.rx_len); i++) slave_q.push_back(v.rx[i]);
      end
      d0 = done_cnt; e0 = err_cnt; s0 = start_cnt; f0 = cs_fall;
      send_cmd(nm, v.mode, v.tx_len, v.rx_len);
      if (v.err) repeat (6) step();
      else wait_done(nm, d0);
      repeat (3) step();
      check({nm, "_err"}, err_cnt - e0, int'(v.err));
      check({nm, "_done"}, done_cnt - d0, int'(!v.err));
      check({nm, "_ready_after"}, int'(cmd_ready), 1);
      if (v.err) begin
         check({nm, "_no_starts"}, start_cnt - s0, 0);
         check({nm, "_no_cs"}, cs_fall - f0, 0);
      end else begin
         check({nm, "_cs_falls"}, cs_fall - f0, 1);
         check({nm, "_mode"}, int'(run_mode), int'(v.mode));
         check({nm, "_mosi_n"}, mosi_q.size(), int'(v.tx_len));
         for (int i = 0; i < mosi_q.size() && i < int'(v.tx_len); i++)
            check($sformatf("%s_mosi%0d", nm, i), int'(mosi_q[i]), int'(v.tx[i]));
         for (int i = 0; i < int'(v.rx_len); i++)
            rx_pop_check($sformatf("%s_rx%0d", nm, i), v.rx[i]);
      end
      check({nm, "_rx_empty"}, int'(rx_valid), 0);
   endtask

   initial begin : main
      int d0, s0, f0, n, cyc;
      vecs[0] = '{MODE0, 4'd1, 4'd3, 32'h0000009F, 32'h001840EF, 1'b0};
      vecs[1] = '{MODE1, 4'd2, 4'd1, 32'h00000201, 32'h000000C3, 1'b0};
      vecs[2] = '{MODE2, 4'd0, 4'd2, 32'h00000000, 32'h00002211, 1'b0};
      vecs[3] = '{MODE3, 4'd3, 4'd0, 32'h000F55AA, 32'h00000000, 1'b0};
      vecs[4] = '{MODE0, 4'd9, 4'd0, 32'h00000000, 32'h00000000, 1'b1};
      vecs[5] = '{MODE1, 4'd0, 4'd9, 32'h00000000, 32'h00000000, 1'b1};
      vecs[6] = '{MODE2, 4'd4, 4'd4, 32'h44332211, 32'hDDCCBBAA, 1'b0};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_tx_len = '0; cmd_rx_len = '0;
      tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      check("rst_cmd_ready", int'(cmd_ready), 1);
      check("rst_xfer_done", int'(xfer_done), 0);
      check("rst_cmd_err", int'(cmd_err), 0);
      check("rst_starts", int'({m_tx_start, m_rx_start}), 0);
      check("rst_m_mode", int'(m_mode), 0);
      check("rst_rx_valid", int'(rx_valid), 0);
      check("rst_rx_data", int'(rx_data), 0);
      check("rst_m_data_in", int'(m_data_in), 0);
      check("rst_tx_ready", int'(tx_ready), 1);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // TX short of tx_len: hold in WAIT until the second byte lands.
      mosi_q.delete();
      tx_write(8'h3C);
      s0 = start_cnt; d0 = done_cnt;
      send_cmd("wait_tx", MODE0, 4'd2, 4'd0);
      repeat (20) step();
      check("wait_tx_starts", start_cnt - s0, 0);
      check("wait_tx_ready", int'(cmd_ready), 0);
      check("wait_tx_tx_start", int'(m_tx_start), 0);
      tx_write(8'hC3);
      wait_done("wait_tx", d0);
      repeat (3) step();
      check("wait_tx_mosi_n", mosi_q.size(), 2);
      if (mosi_q.size() == 2) begin
         check("wait_tx_mosi0", int'(mosi_q[0]), 8'h3C);
         check("wait_tx_mosi1", int'(mosi_q[1]), 8'hC3);
      end

      // Zero-length command; the acceptance cycle counts as cycle 1.
      s0 = start_cnt; f0 = cs_fall;
      send_cmd("zero", MODE1, 4'd0, 4'd0);
      n = 1;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (xfer_done) break;
      end
      check("zero_done_cycle", n, 3);
      repeat (3) step();
      check("zero_no_starts", start_cnt - s0, 0);
      check("zero_no_cs", cs_fall - f0, 0);
      check("zero_ready", int'(cmd_ready), 1);

      // RX FIFO at 7/8 blocks rx_len=2 until one word is popped.
      for (int i = 1; i <= 7; i++) slave_q.push_back(8'(i));
      d0 = done_cnt;
      send_cmd("fill", MODE0, 4'd0, 4'd7);
      wait_done("fill", d0);
      repeat (3) step();
      slave_q.push_back(8'hA1);
      slave_q.push_back(8'hA2);
      s0 = start_cnt; d0 = done_cnt;
      send_cmd("rxfull", MODE2, 4'd0, 4'd2);
      repeat (30) step();
      check("rxfull_starts", start_cnt - s0, 0);
      check("rxfull_ready", int'(cmd_ready), 0);
      rx_pop_check("rxfull_pop0", 8'h01);
      wait_done("rxfull", d0);
      repeat (3) step();
      for (int i = 2; i <= 7; i++) rx_pop_check($sformatf("rxfull_pop%0d", i - 1), 8'(i));
      rx_pop_check("rxfull_a1", 8'hA1);
      rx_pop_check("rxfull_a2", 8'hA2);
      check("rxfull_empty", int'(rx_valid), 0);

      // Reset during the second byte of a mode-3 transmit, with a spare byte left in TX.
      mosi_q.delete();
      tx_write(8'hA5);
      tx_write(8'h5A);
      tx_write(8'h77);
      send_cmd("rst_run", MODE3, 4'd2, 4'd0);
      cyc = 0;
      while (mosi_q.size() < 1 && cyc < 200) begin
         step();
         cyc++;
      end
      check("rst_run_first_byte", int'(cyc < 200), 1);
      repeat (3) step();
      check("rst_run_mode", int'(m_mode), int'(MODE3));
      check("rst_run_busy", int'(cmd_ready), 0);
      rst_n = 1'b0;
      #1;
      check("rst_run_starts", int'({m_tx_start, m_rx_start}), 0);
      check("rst_run_cmd_ready", int'(cmd_ready), 1);
      check("rst_run_tx_empty", int'(m_data_in), 0);
      check("rst_run_rx_valid", int'(rx_valid), 0);
      check("rst_run_m_mode", int'(m_mode), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      slave_q.delete();
      step();
      step();
      check("rst_run_mosi_n", mosi_q.size(), 1);
      run_vec(vecs[0], 7);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
